// File: rtl/usr_serial_deser.sv
// Serial-to-parallel receiver for a universal shift register bitstream.
// Strobed bits are assembled MSB- or LSB-first and queued in a 2-entry FIFO.
module usr_serial_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [1:0]       level,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r;
    logic            dir_r;
    logic [CW-1:0]   cnt_r;
    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]      level_r;
    logic            overrun_r;

    logic            dir_s;
    logic [WIDTH-1:0] word_s;
    logic            push_s;
    logic            pop_s;

    // Next assembled word; the first bit of a word uses the live msb_first input.
    always_comb begin
        dir_s  = dir_r;
        word_s = sh_r;
        if (state_r == IDLE) begin
            dir_s = msb_first;
        end else begin
            dir_s = dir_r;
        end
        if (dir_s) begin
            word_s = {sh_r[WIDTH-2:0], sin};
        end else begin
            word_s = {sin, sh_r[WIDTH-1:1]};
        end
        push_s = sin_valid & ~flush & (state_r == SHIFT) & (cnt_r == LAST);
        pop_s  = (level_r != 2'd0) & dout_ready;
    end

    // Bit-collection FSM; flush outranks an incoming bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            dir_r   <= 1'b0;
            cnt_r   <= CW'(0);
            sh_r    <= {WIDTH{1'b0}};
        end else if (flush) begin
            state_r <= IDLE;
            cnt_r   <= CW'(0);
            sh_r    <= {WIDTH{1'b0}};
        end else if (sin_valid) begin
            case (state_r)
                IDLE: begin
                    dir_r   <= msb_first;
                    sh_r    <= word_s;
                    cnt_r   <= CW'(1);
                    state_r <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_r == LAST) begin
                        sh_r    <= {WIDTH{1'b0}};
                        cnt_r   <= CW'(0);
                        state_r <= IDLE;
                    end else begin
                        sh_r  <= word_s;
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CW'(0);
                    sh_r    <= {WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Two-entry FIFO kept as head/tail registers; empty slots hold zero so dout is 0 when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r    <= {WIDTH{1'b0}};
            tail_r    <= {WIDTH{1'b0}};
            level_r   <= 2'd0;
            overrun_r <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (level_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= word_s;
                    end else begin
                        head_r <= word_s;
                    end
                end
                2'b01: begin
                    head_r  <= tail_r;
                    tail_r  <= {WIDTH{1'b0}};
                    level_r <= level_r - 2'd1;
                end
                2'b10: begin
                    if (level_r == 2'd0) begin
                        head_r  <= word_s;
                        level_r <= 2'd1;
                    end else if (level_r == 2'd1) begin
                        tail_r  <= word_s;
                        level_r <= 2'd2;
                    end else begin
                        level_r <= level_r;
                    end
                end
                default: begin
                    level_r <= level_r;
                end
            endcase
            if (push_s && !pop_s && (level_r == 2'd2)) begin
                overrun_r <= 1'b1;
            end else if (clr_ovr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign dout       = head_r;
    assign dout_valid = (level_r != 2'd0);
    assign level      = level_r;
    assign overrun    = overrun_r;
    assign busy       = (state_r == SHIFT);

endmodule

// File: tb/tb_usr_serial_deser.sv
// Directed bench for usr_serial_deser: expected words queue up as bits are sent
// and are checked against dout whenever a pop is about to happen.
module tb_usr_serial_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         msb_first = 1'b1;
    logic         flush = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         busy;
    logic [1:0]   level;
    logic         overrun;
    logic         clr_ovr = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    usr_serial_deser #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .msb_first(msb_first), .flush(flush), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
        .level(level), .overrun(overrun), .clr_ovr(clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Inputs are stable at the falling edge, so a pop at the next rising edge is certain.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                check("pop_word", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    // First bit sent becomes word[W-1] when MSB-first, word[0] when LSB-first.
    function automatic logic [W-1:0] assemble(input logic [W-1:0] seq, input logic m);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) begin
            if (m) w[W-1-i] = seq[W-1-i];
            else   w[i]     = seq[W-1-i];
        end
        return w;
    endfunction

    // seq[W-1] is transmitted first; gap idle cycles separate consecutive bits.
    task automatic send_word(input logic [W-1:0] seq, input logic m, input int gap,
                             input logic keep, input logic rdy_last);
        msb_first = m;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1 && rdy_last) dout_ready = 1'b1;
            send_bit(seq[W-1-i]);
            if (i == 1) msb_first = ~m;
            if (i < W - 1) begin
                check("busy_mid", 32'(busy), 32'd1);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_gap", 32'(busy), 32'd1);
                end
            end
        end
        check("busy_end", 32'(busy), 32'd0);
        if (keep) exp_q.push_back(assemble(seq, m));
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        // MSB-first word, one-cycle latency, popped immediately
        dout_ready = 1'b1;
        check("busy_idle", 32'(busy), 32'd0);
        send_word(4'b1011, 1'b1, 0, 1'b1, 1'b0);
        check("t1_valid", 32'(dout_valid), 32'd1);
        check("t1_dout", 32'(dout), 32'hB);
        tick();
        check("t1_level", 32'(level), 32'd0);

        // LSB-first, back-to-back and with gaps
        send_word(4'b1011, 1'b0, 0, 1'b1, 1'b0);
        check("t2_dout", 32'(dout), 32'hD);
        tick();
        send_word(4'b1011, 1'b0, 3, 1'b1, 1'b0);
        check("t2g_dout", 32'(dout), 32'hD);
        tick();

        // fill, overflow, drain, clear
        dout_ready = 1'b0;
        send_word(4'hA, 1'b1, 0, 1'b1, 1'b0);
        check("t3_lvl1", 32'(level), 32'd1);
        send_word(4'h5, 1'b1, 0, 1'b1, 1'b0);
        check("t3_lvl2", 32'(level), 32'd2);
        check("t3_no_ovr", 32'(overrun), 32'd0);
        send_word(4'hC, 1'b1, 0, 1'b0, 1'b0);
        check("t3_lvl_full", 32'(level), 32'd2);
        check("t3_ovr", 32'(overrun), 32'd1);
        check("t3_head", 32'(dout), 32'hA);
        dout_ready = 1'b1;
        tick();
        check("t3_second", 32'(dout), 32'h5);
        tick();
        check("t3_empty", 32'(level), 32'd0);
        check("t3_dout0", 32'(dout), 32'd0);
        check("t3_ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("t3_clr", 32'(overrun), 32'd0);

        // push and pop on the same edge while full
        dout_ready = 1'b0;
        send_word(4'hA, 1'b1, 0, 1'b1, 1'b0);
        send_word(4'h5, 1'b1, 0, 1'b1, 1'b0);
        send_word(4'h3, 1'b1, 0, 1'b1, 1'b1);
        check("t4_level", 32'(level), 32'd2);
        check("t4_no_ovr", 32'(overrun), 32'd0);
        check("t4_head", 32'(dout), 32'h5);
        tick();
        tick();
        check("t4_drained", 32'(level), 32'd0);

        // flush mid-word, then flush with a coincident bit in IDLE
        msb_first = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_busy", 32'(busy), 32'd0);
        check("t5_flush_lvl", 32'(level), 32'd0);
        send_word(4'b0110, 1'b1, 0, 1'b1, 1'b0);
        check("t5_dout", 32'(dout), 32'h6);
        check("t5_level", 32'(level), 32'd1);
        tick();
        flush = 1'b1;
        sin = 1'b1;
        sin_valid = 1'b1;
        tick();
        flush = 1'b0;
        sin_valid = 1'b0;
        check("t5_flush_bit", 32'(busy), 32'd0);
        send_word(4'b1001, 1'b0, 0, 1'b1, 1'b0);
        check("t5b_dout", 32'(dout), 32'h9);
        tick();

        // asynchronous reset mid-word with words queued and overrun set
        dout_ready = 1'b0;
        send_word(4'h9, 1'b1, 0, 1'b1, 1'b0);
        send_word(4'h2, 1'b1, 0, 1'b1, 1'b0);
        send_word(4'h7, 1'b1, 0, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t6_pre_busy", 32'(busy), 32'd1);
        check("t6_pre_ovr", 32'(overrun), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(dout_valid), 32'd0);
        check("t6_dout", 32'(dout), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_ovr", 32'(overrun), 32'd0);
        exp_q.delete();
        #1;
        rst = 1'b0;
        tick();
        dout_ready = 1'b1;
        send_word(4'hF, 1'b1, 0, 1'b1, 1'b0);
        check("t6_dout_f", 32'(dout), 32'hF);
        tick();
        tick();
        check("end_level", 32'(level), 32'd0);
        check("end_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
